// File: rtl/vga_pkg.sv
// Shared VGA raster constants, the per-axis phase type and the phase decoder
// used by both the horizontal and the vertical counters.
package vga_pkg;

   localparam int COORD_W = 10;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

   function automatic phase_t phase_of(input logic [COORD_W-1:0] count,
                                       input int visible,
                                       input int front,
                                       input int sync);
      phase_t ph;
      int     c;
      c = int'(count);
      if (c < visible)
         ph = PH_ACTIVE;
      else if (c < visible + front)
         ph = PH_FRONT;
      else if (c < visible + front + sync)
         ph = PH_SYNC;
      else
         ph = PH_BACK;
      return ph;
   endfunction

endpackage

// File: rtl/vga_sync_gen_axis_counter.sv
// One raster axis: wrapping counter with enable, and registered sync/terminal
// flags decoded from the next count so they line up with the count itself.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int   VISIBLE     = DEF_H_VISIBLE,
   parameter int   FRONT       = DEF_H_FRONT,
   parameter int   SYNC        = DEF_H_SYNC,
   parameter int   BACK        = DEF_H_BACK,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [COORD_W-1:0] count,
   output phase_t             phase_next,
   output logic               sync,
   output logic               terminal
);

   localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

   logic [COORD_W-1:0] count_next;

   always_comb begin
      count_next = count;
      if (en) begin
         if (count == COORD_W'(TOTAL - 1))
            count_next = '0;
         else
            count_next = count + COORD_W'(1);
      end
      phase_next = phase_of(count_next, VISIBLE, FRONT, SYNC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         sync     <= ~SYNC_ACTIVE;
         terminal <= 1'b0;
      end else if (en) begin
         count    <= count_next;
         sync     <= (phase_next == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         terminal <= (count_next == COORD_W'(TOTAL - 1));
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing generator: sync pulses, visible-area flag, pixel
// coordinates, end-of-line and start-of-frame strobes, all registered.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int   H_VISIBLE   = DEF_H_VISIBLE,
   parameter int   H_FRONT     = DEF_H_FRONT,
   parameter int   H_SYNC      = DEF_H_SYNC,
   parameter int   H_BACK      = DEF_H_BACK,
   parameter int   V_VISIBLE   = DEF_V_VISIBLE,
   parameter int   V_FRONT     = DEF_V_FRONT,
   parameter int   V_SYNC      = DEF_V_SYNC,
   parameter int   V_BACK      = DEF_V_BACK,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               line_end,
   output logic               frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // A total beyond the counter range would silently alias coordinates.
   if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_size_check
      $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
   end

   phase_t h_phase_next;
   phase_t v_phase_next;
   logic   h_terminal;
   logic   v_terminal;
   logic   v_en;

   // The line counter advances only on the clock where the pixel counter wraps.
   assign v_en = en & h_terminal;

   vga_axis_counter #(
      .VISIBLE    (H_VISIBLE),
      .FRONT      (H_FRONT),
      .SYNC       (H_SYNC),
      .BACK       (H_BACK),
      .SYNC_ACTIVE(SYNC_ACTIVE)
   ) u_h (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .count     (pixel_x),
      .phase_next(h_phase_next),
      .sync      (hsync),
      .terminal  (h_terminal)
   );

   vga_axis_counter #(
      .VISIBLE    (V_VISIBLE),
      .FRONT      (V_FRONT),
      .SYNC       (V_SYNC),
      .BACK       (V_BACK),
      .SYNC_ACTIVE(SYNC_ACTIVE)
   ) u_v (
      .clk       (clk),
      .rst       (rst),
      .en        (v_en),
      .count     (pixel_y),
      .phase_next(v_phase_next),
      .sync      (vsync),
      .terminal  (v_terminal)
   );

   assign line_end = h_terminal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         video_on    <= 1'b1;
         frame_start <= 1'b0;
      end else if (en) begin
         video_on    <= (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
         // Both counters sitting on their last count means the next pixel is (0,0).
         frame_start <= h_terminal & v_terminal;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: the driver pushes the expected outputs of each clock into a
// queue, a monitor pops and compares them on the following falling edge.
module tb_vga_sync_gen;

   typedef struct {
      int x;
      int y;
      bit hs;
      bit vs;
      bit vo;
      bit le;
      bit fs;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;

   logic       hsync0, vsync0, video_on0, line_end0, frame_start0;
   logic [9:0] pixel_x0, pixel_y0;
   logic       hsync1, vsync1, video_on1, line_end1, frame_start1;
   logic [9:0] pixel_x1, pixel_y1;

   exp_t q0[$];
   exp_t q1[$];
   exp_t s0, s1;
   int   vectors = 0;
   int   misses  = 0;

   always #5 clk = ~clk;

   vga_sync_gen dut0 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .hsync      (hsync0),
      .vsync      (vsync0),
      .video_on   (video_on0),
      .pixel_x    (pixel_x0),
      .pixel_y    (pixel_y0),
      .line_end   (line_end0),
      .frame_start(frame_start0)
   );

   // Small raster with inverted sync polarity so whole frames fit a short run.
   vga_sync_gen #(
      .H_VISIBLE  (16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
      .V_VISIBLE  (8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .SYNC_ACTIVE(1'b1)
   ) dut1 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .hsync      (hsync1),
      .vsync      (vsync1),
      .video_on   (video_on1),
      .pixel_x    (pixel_x1),
      .pixel_y    (pixel_y1),
      .line_end   (line_end1),
      .frame_start(frame_start1)
   );

   function automatic exp_t reset_exp(input bit act);
      exp_t r;
      r.x  = 0;
      r.y  = 0;
      r.hs = !act;
      r.vs = !act;
      r.vo = 1'b1;
      r.le = 1'b0;
      r.fs = 1'b0;
      return r;
   endfunction

   function automatic exp_t adv(input exp_t c, input bit e,
                                input int hv, input int hf, input int hw, input int hb,
                                input int vv, input int vf, input int vw, input int vb,
                                input bit act);
      exp_t n;
      int   ht, vt;
      ht = hv + hf + hw + hb;
      vt = vv + vf + vw + vb;
      if (!e) return c;
      n   = c;
      n.x = c.x + 1;
      if (c.x == ht - 1) begin
         n.x = 0;
         n.y = (c.y == vt - 1) ? 0 : c.y + 1;
      end
      n.hs = (n.x >= hv + hf && n.x < hv + hf + hw) ? act : !act;
      n.vs = (n.y >= vv + vf && n.y < vv + vf + vw) ? act : !act;
      n.vo = (n.x < hv) && (n.y < vv);
      n.le = (n.x == ht - 1);
      n.fs = (n.x == 0) && (n.y == 0);
      return n;
   endfunction

   function automatic exp_t adv0(input exp_t c, input bit e);
      return adv(c, e, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic exp_t adv1(input exp_t c, input bit e);
      return adv(c, e, 16, 4, 8, 4, 8, 2, 2, 3, 1'b1);
   endfunction

   task automatic compare(input string tag, input exp_t e, input int ax, input int ay,
                          input bit hs, input bit vs, input bit vo, input bit le, input bit fs);
      vectors++;
      if (ax != e.x || ay != e.y || hs != e.hs || vs != e.vs ||
          vo != e.vo || le != e.le || fs != e.fs) begin
         misses++;
         if (misses <= 20)
            $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b vo=%b le=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b vo=%b le=%b fs=%b",
                     tag, $time, ax, ay, hs, vs, vo, le, fs,
                     e.x, e.y, e.hs, e.vs, e.vo, e.le, e.fs);
      end
   endtask

   task automatic tally(input string tag, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         misses++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end else begin
         $display("check %s: %0d", tag, actual);
      end
   endtask

   // Monitor: compare every queued expectation against the settled outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q0.size() > 0) begin
            e = q0.pop_front();
            compare("dut0", e, int'(pixel_x0), int'(pixel_y0), hsync0, vsync0,
                    video_on0, line_end0, frame_start0);
         end
         while (q1.size() > 0) begin
            e = q1.pop_front();
            compare("dut1", e, int'(pixel_x1), int'(pixel_y1), hsync1, vsync1,
                    video_on1, line_end1, frame_start1);
         end
      end
   end

   task automatic step(input bit e, input bit r);
      @(negedge clk);
      en  = e;
      rst = r;
      @(posedge clk);
      if (r) begin
         s0 = reset_exp(1'b0);
         s1 = reset_exp(1'b1);
      end else begin
         s0 = adv0(s0, e);
         s1 = adv1(s1, e);
      end
      q0.push_back(s0);
      q1.push_back(s1);
      #1;
   endtask

   initial begin
      int  hs_lo0, vo_lo0, le0, fs0, vs_act1, fs1, hs_act1, fs_rst;
      bit  en_pat[4];
      int  x_pat[4];

      en_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      x_pat  = '{101, 101, 101, 102};
      hs_lo0 = 0; vo_lo0 = 0; le0 = 0; fs0 = 0;
      vs_act1 = 0; fs1 = 0; hs_act1 = 0; fs_rst = 0;
      s0 = reset_exp(1'b0);
      s1 = reset_exp(1'b1);

      repeat (3) step(1'b0, 1'b1);
      step(1'b1, 1'b1);

      // First line of the default raster; one full small frame on dut1.
      for (int i = 0; i < 800; i++) begin
         step(1'b1, 1'b0);
         if (!hsync0)      hs_lo0++;
         if (!video_on0)   vo_lo0++;
         if (line_end0)    le0++;
         if (frame_start0) fs0++;
         if (i < 480) begin
            if (vsync1)       vs_act1++;
            if (hsync1)       hs_act1++;
            if (frame_start1) fs1++;
         end
      end
      tally("hsync0_low_clocks", hs_lo0, 96);
      tally("video0_off_clocks", vo_lo0, 160);
      tally("line_end0_pulses", le0, 1);
      tally("frame_start0_on_release", fs0, 0);
      tally("x0_after_line", int'(pixel_x0), 0);
      tally("y0_after_line", int'(pixel_y0), 1);
      tally("vsync1_active_clocks", vs_act1, 64);
      tally("hsync1_active_clocks", hs_act1, 120);
      tally("frame_start1_pulses", fs1, 1);

      repeat (100) step(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(en_pat[i], 1'b0);
         tally("en_hold_x0", int'(pixel_x0), x_pat[i]);
      end

      // Move to (300,1) then hit reset between edges.
      repeat (198) step(1'b1, 1'b0);
      tally("x0_before_reset", int'(pixel_x0), 300);
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      s0 = adv0(s0, 1'b1);
      s1 = adv1(s1, 1'b1);
      #2;
      rst = 1'b1;
      s0 = reset_exp(1'b0);
      s1 = reset_exp(1'b1);
      q0.push_back(s0);
      q1.push_back(s1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 0; i < 50; i++) begin
         step(1'b1, 1'b0);
         if (frame_start0) fs_rst++;
      end
      tally("x0_after_reset", int'(pixel_x0), 50);
      tally("frame_start0_after_reset", fs_rst, 0);

      repeat (1000) step(1'b1, 1'b0);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumer end of the pixel clock that the clock converter produces: the 25 MHz VGA clock drives the counters here.
- Generates 640x480@60 Hz raster timing: hsync, vsync, video_on and the current pixel coordinates.
- Emits a one-cycle frame_start strobe so the game-update logic can latch Guy/Cake positions between frames.
- Sits between the clock converter and the pixel/colour generator.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of hsync/vsync while asserted

Ports:
- clk  in  1  25 MHz VGA pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  pixel enable; counters advance only when high; tie to 1 for free-run
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while (pixel_x, pixel_y) is inside the visible area
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- line_end  out  1  one-cycle pulse on the last clock of every line
- frame_start  out  1  one-cycle pulse coinciding with pixel (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (800 with defaults).
  - V_TOTAL = sum of the V_* parameters (525 with defaults).
- Reset (asynchronous, active-high) drives:
  - pixel_x = 0, pixel_y = 0
  - hsync = vsync = ~SYNC_ACTIVE
  - video_on = 1, because (0,0) is a visible pixel
  - line_end = 0, frame_start = 0
- Counting, on each clk edge with en=1:
  - pixel_x increments by 1.
  - At H_TOTAL-1, pixel_x wraps to 0 and pixel_y increments.
  - When pixel_y is also at V_TOTAL-1, pixel_y wraps to 0.
- With en=0, every output holds its value. Pulses held high at that point also hold, so consumers qualify them with en.
- All outputs are registered. Output decodes are computed from the next-state counts, so every output is aligned with the pixel_x/pixel_y shown on the same cycle (zero latency relative to the counters).
- Horizontal phase, decoded from pixel_x:
  - ACTIVE: 0..639
  - FRONT: 640..655
  - SYNC: 656..751, hsync = SYNC_ACTIVE
  - BACK: 752..799
- Vertical phase, decoded from pixel_y with the same structure:
  - ACTIVE: 0..479
  - FRONT: 480..489
  - SYNC: 490..491, vsync = SYNC_ACTIVE
  - BACK: 492..524
- vsync changes only when pixel_x wraps to 0.
- video_on = 1 only when both the horizontal and vertical phases are ACTIVE.
- line_end = 1 exactly when pixel_x = H_TOTAL-1.
- frame_start = 1 exactly when pixel_x = 0 and pixel_y = 0 after a wrap. It does not pulse on release from reset.
- Width rule: counters are 10 bits. Parameter sums above 1024 are illegal; implementation flags them with an elaboration-time check.
- Reset mid-frame: counters return to (0,0) immediately. No partial pulses are produced on the clock edge after release.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants and derived H_TOTAL/V_TOTAL;
  - a 2-bit phase enumeration (PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK);
  - the coordinate width constant (10).
- One natural sub-module, vga_axis_counter, instantiated twice (horizontal and vertical):
  - wrapping counter with count enable;
  - phase decode;
  - terminal-count output.
  - Its terminal-count output chains into the vertical instance's enable.

Test Plan:
- Reset release, en=1, run 800 clocks:
  - pixel_x steps 0..799 then returns to 0;
  - pixel_y steps to 1;
  - line_end high only at pixel_x=799.
- Horizontal sync check:
  - hsync=0 exactly for pixel_x 656..751 (96 clocks);
  - video_on=0 for pixel_x 640..799.
- Full frame (420000 clocks):
  - vsync=0 for pixel_y 490..491 (1600 clocks);
  - frame_start pulses once, at the wrap to (0,0);
  - no pulse at reset release.
- en toggled 1,0,0,1 at pixel_x=100: pixel_x reads 101,101,101,102 and all outputs are stable while en=0.
- Assert rst asynchronously at pixel (300,200) between clock edges: outputs take their reset values before the next edge and counting resumes from 0 after release.
- SYNC_ACTIVE=1 build: hsync/vsync polarity inverted, all other timing identical to the default-build checks.
